// File: rtl/img_pkg.sv
`default_nettype none
// img_pkg: shared image defaults, sequencer state encoding and counter-width helper.
// Rev 1.0
package img_pkg;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_DW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// line_buffer: one image line of storage, combinational read and synchronous write at the same address.
// Rev 1.0
module line_buffer
  import img_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_DW,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Contents are intentionally not reset; readers gate out stale lines.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_ctrl.sv
`default_nettype none
// window_ctrl: turns a raster pixel stream into registered 3x3 windows and signals frame end after drain.
// Rev 1.0
module window_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int DW       = DEF_DW,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] pix_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  output logic [DW-1:0] d0_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic [DW-1:0] d3_o,
  output logic [DW-1:0] d4_o,
  output logic [DW-1:0] d5_o,
  output logic [DW-1:0] d6_o,
  output logic [DW-1:0] d7_o,
  output logic [DW-1:0] d8_o,
  output logic          win_valid_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int DRN_W = cnt_w(PIPE_LAT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [DRN_W-1:0] drain_cnt;
  logic             accept;
  logic             last_pix;
  logic             drain_end;
  logic [DW-1:0]    lb0_rd;
  logic [DW-1:0]    lb1_rd;
  logic [DW-1:0]    win [9];
  logic             win_valid;

  assign accept    = pix_valid_i && (state == STREAM);
  assign last_pix  = accept && (col == COL_LAST) && (row == ROW_LAST);
  assign drain_end = (drain_cnt == DRN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pix_ready_o  = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        pix_ready_o = 1'b1;
        if (last_pix) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        frame_done_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) && start_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state != DRAIN)) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Columns shift left; the new rightmost column comes from both line buffers and the live pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
      win_valid <= 1'b0;
    end else begin
      win_valid <= accept && (row >= ROW_TWO) && (col >= COL_TWO);
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_i;
      end
    end
  end

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DW),
    .AW    (COL_W)
  ) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix_i),
    .rdata (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DW),
    .AW    (COL_W)
  ) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  assign d0_o        = win[0];
  assign d1_o        = win[1];
  assign d2_o        = win[2];
  assign d3_o        = win[3];
  assign d4_o        = win[4];
  assign d5_o        = win[5];
  assign d6_o        = win[6];
  assign d7_o        = win[7];
  assign d8_o        = win[8];
  assign win_valid_o = win_valid;

endmodule
`default_nettype wire
